// File: rtl/clusterv_main_sram_arb.sv
// -----------------------------------------------------------------------------
// clusterv_main_sram_arb
//
// Connects N_REQ requesters to N_BANKS single-cycle main-SRAM banks. Each bank
// has its own round-robin arbiter, so requesters that address different banks
// are all granted in the same cycle. Grants are combinational. Read data comes
// back one cycle after acceptance on the requester's own response lane.
//
// Ports (per-requester and per-bank buses are packed, index i at [W*i +: W]):
//   clock            sole clock, rising edge
//   reset            synchronous, active-low
//   req_valid        per-requester request pending
//   req_ready        per-requester grant this cycle (combinational)
//   req_addr         word address; the top BS_W bits select the bank
//   req_we           1 = write, 0 = read
//   req_byte_en      write byte lanes
//   req_write_data   write data
//   rsp_valid        read data valid, one cycle after a read is accepted
//   rsp_read_data    read data, zero when rsp_valid is low
//   bank_addr        per-bank word address
//   bank_read_en     per-bank read strobe
//   bank_write_en    per-bank write strobe
//   bank_byte_en     per-bank byte enables (all ones on reads)
//   bank_write_data  per-bank write data
//   bank_read_data   per-bank read data, valid one cycle after bank_read_en
// -----------------------------------------------------------------------------
module clusterv_main_sram_arb #(
    parameter int N_REQ          = 2,
    parameter int N_BANKS        = 4,
    parameter int BANK_ADR_WIDTH = 10,
    parameter int DAT_WIDTH      = 32,
    localparam int BS_W          = $clog2(N_BANKS),
    localparam int A_W           = BANK_ADR_WIDTH + BS_W,
    localparam int BE_W          = DAT_WIDTH / 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*A_W-1:0]          req_addr,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*BE_W-1:0]         req_byte_en,
    input  logic [N_REQ*DAT_WIDTH-1:0]    req_write_data,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [N_REQ*DAT_WIDTH-1:0]    rsp_read_data,
    output logic [N_BANKS*BANK_ADR_WIDTH-1:0] bank_addr,
    output logic [N_BANKS-1:0]            bank_read_en,
    output logic [N_BANKS-1:0]            bank_write_en,
    output logic [N_BANKS*BE_W-1:0]       bank_byte_en,
    output logic [N_BANKS*DAT_WIDTH-1:0]  bank_write_data,
    input  logic [N_BANKS*DAT_WIDTH-1:0]  bank_read_data
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Round-robin pointer per bank: the requester searched first next cycle.
    logic [RR_W-1:0] rr_ptr      [N_BANKS];
    logic [RR_W-1:0] bank_winner [N_BANKS];
    logic [N_BANKS-1:0] bank_grant;

    // Read tracking: which requesters have a read in flight and from where.
    logic [N_REQ-1:0] rd_accept;
    logic [BS_W-1:0]  acc_bank [N_REQ];
    logic [N_REQ-1:0] rd_pend;
    logic [BS_W-1:0]  rd_bank  [N_REQ];

    // Per-bank arbitration and bank-port muxing. A requester targets exactly
    // one bank, so it can never win more than one grant per cycle.
    always_comb begin : arbitrate
        int              idx;
        logic [BS_W-1:0] sel;
        // NOTE: every signal written here gets a default before any branch,
        // so no path leaves a value held and no latch is inferred.
        idx             = 0;
        sel             = '0;
        req_ready       = '0;
        bank_grant      = '0;
        rd_accept       = '0;
        bank_addr       = '0;
        bank_read_en    = '0;
        bank_write_en   = '0;
        bank_byte_en    = '0;
        bank_write_data = '0;
        for (int b = 0; b < N_BANKS; b++) bank_winner[b] = '0;
        for (int i = 0; i < N_REQ; i++)   acc_bank[i]    = '0;

        // Grants and strobes are suppressed while reset is held.
        if (reset) begin
            for (int b = 0; b < N_BANKS; b++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    idx = (int'(rr_ptr[b]) + j) % N_REQ;
                    sel = req_addr[A_W*idx + A_W-1 -: BS_W];
                    if (!bank_grant[b] && req_valid[idx] && sel == BS_W'(b)) begin
                        bank_grant[b]  = 1'b1;
                        bank_winner[b] = RR_W'(idx);
                    end
                end
                if (bank_grant[b]) begin
                    idx            = int'(bank_winner[b]);
                    req_ready[idx] = 1'b1;
                    bank_addr[BANK_ADR_WIDTH*b +: BANK_ADR_WIDTH] =
                        req_addr[A_W*idx +: BANK_ADR_WIDTH];
                    bank_write_en[b] = req_we[idx];
                    bank_read_en[b]  = ~req_we[idx];
                    bank_byte_en[BE_W*b +: BE_W] =
                        req_we[idx] ? req_byte_en[BE_W*idx +: BE_W] : {BE_W{1'b1}};
                    bank_write_data[DAT_WIDTH*b +: DAT_WIDTH] =
                        req_write_data[DAT_WIDTH*idx +: DAT_WIDTH];
                    rd_accept[idx] = ~req_we[idx];
                    acc_bank[idx]  = BS_W'(b);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int b = 0; b < N_BANKS; b++) rr_ptr[b] <= '0;
            rd_pend <= '0;
            for (int i = 0; i < N_REQ; i++) rd_bank[i] <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (bank_grant[b]) begin
                    rr_ptr[b] <= (bank_winner[b] == RR_W'(N_REQ-1)) ? '0
                                 : bank_winner[b] + RR_W'(1);
                end
            end
            rd_pend <= rd_accept;
            for (int i = 0; i < N_REQ; i++) begin
                if (rd_accept[i]) rd_bank[i] <= acc_bank[i];
            end
        end
    end

    // Response lanes. rsp_valid is masked by reset so a read accepted just
    // before reset asserts never reports data; the pending flag clears on the
    // reset edge that follows.
    always_comb begin : respond
        rsp_valid     = rd_pend & {N_REQ{reset}};
        rsp_read_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rsp_valid[i]) begin
                rsp_read_data[DAT_WIDTH*i +: DAT_WIDTH] =
                    bank_read_data[DAT_WIDTH*int'(rd_bank[i]) +: DAT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_clusterv_main_sram_arb.sv
// -----------------------------------------------------------------------------
// Testbench for clusterv_main_sram_arb: directed scenarios followed by random
// traffic. A reference model picks per-bank winners from the round-robin rule,
// predicts bank-port values and pushes expected read responses into
// per-requester queues; a separate monitor pops them when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_clusterv_main_sram_arb;

    localparam int N_REQ   = 2;
    localparam int N_BANKS = 4;
    localparam int BAW     = 10;
    localparam int DW      = 32;
    localparam int BS_W    = 2;
    localparam int A_W     = BAW + BS_W;
    localparam int BE_W    = DW / 8;
    localparam int DEPTH   = 1 << BAW;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_W-1:0]     req_addr;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*BE_W-1:0]    req_byte_en;
    logic [N_REQ*DW-1:0]      req_write_data;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ*DW-1:0]      rsp_read_data;
    logic [N_BANKS*BAW-1:0]   bank_addr;
    logic [N_BANKS-1:0]       bank_read_en;
    logic [N_BANKS-1:0]       bank_write_en;
    logic [N_BANKS*BE_W-1:0]  bank_byte_en;
    logic [N_BANKS*DW-1:0]    bank_write_data;
    logic [N_BANKS*DW-1:0]    bank_read_data = '0;

    always #5 clock = ~clock;

    clusterv_main_sram_arb #(
        .N_REQ(N_REQ), .N_BANKS(N_BANKS), .BANK_ADR_WIDTH(BAW), .DAT_WIDTH(DW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_byte_en(req_byte_en), .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data),
        .bank_addr(bank_addr), .bank_read_en(bank_read_en),
        .bank_write_en(bank_write_en), .bank_byte_en(bank_byte_en),
        .bank_write_data(bank_write_data), .bank_read_data(bank_read_data)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q   [N_REQ][$];
    logic [DW-1:0] sram    [N_BANKS][DEPTH];  // bank contents seen by the DUT
    logic [DW-1:0] ref_mem [N_BANKS][DEPTH];  // model's view of the same data
    int            rr_m    [N_BANKS];
    int            cycle    = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Values sampled by the stimulus process at each falling edge.
    logic [N_REQ-1:0]   s_ready, s_rsp_valid;
    logic [N_REQ*DW-1:0] s_rsp_data;
    logic [N_BANKS-1:0] s_bank_re, s_bank_we;
    logic [N_BANKS*BE_W-1:0] s_bank_be;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clock) cycle <= cycle + 1;

    // Synchronous SRAM banks: one-cycle read latency, byte-masked writes.
    always @(posedge clock) begin
        for (int b = 0; b < N_BANKS; b++) begin
            if (bank_read_en[b])
                bank_read_data[DW*b +: DW] <= sram[b][bank_addr[BAW*b +: BAW]];
            if (bank_write_en[b]) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bank_byte_en[BE_W*b + k])
                        sram[b][bank_addr[BAW*b +: BAW]][8*k +: 8] <= bank_write_data[DW*b + 8*k +: 8];
                end
            end
        end
    end

    // Reference model: winner = valid requester on this bank nearest to the
    // bank's pointer going upward (modulo N_REQ).
    always @(negedge clock) begin : model
        logic [N_REQ-1:0] exp_ready;
        int               win, best, d, addr_i, off;
        logic [DW-1:0]    wd, cur;
        logic [BE_W-1:0]  be_i;
        exp_t             e;
        if (!reset) begin
            for (int b = 0; b < N_BANKS; b++) rr_m[b] = 0;
            check("reset_req_ready", 64'(req_ready), 64'(0));
            check("reset_bank_read_en", 64'(bank_read_en), 64'(0));
            check("reset_bank_write_en", 64'(bank_write_en), 64'(0));
            check("reset_bank_byte_en", 64'(bank_byte_en), 64'(0));
        end else begin
            exp_ready = '0;
            for (int b = 0; b < N_BANKS; b++) begin
                win  = -1;
                best = N_REQ;
                for (int i = 0; i < N_REQ; i++) begin
                    addr_i = int'(req_addr[A_W*i +: A_W]);
                    d      = (i - rr_m[b] + N_REQ) % N_REQ;
                    if (req_valid[i] && (addr_i / DEPTH) == b && d < best) begin
                        best = d;
                        win  = i;
                    end
                end
                if (win < 0) begin
                    check("idle_bank_read_en", 64'(bank_read_en[b]), 64'(0));
                    check("idle_bank_write_en", 64'(bank_write_en[b]), 64'(0));
                    check("idle_bank_byte_en", 64'(bank_byte_en[BE_W*b +: BE_W]), 64'(0));
                    check("idle_bank_addr", 64'(bank_addr[BAW*b +: BAW]), 64'(0));
                    check("idle_bank_write_data", 64'(bank_write_data[DW*b +: DW]), 64'(0));
                end else begin
                    off  = int'(req_addr[A_W*win +: A_W]) % DEPTH;
                    be_i = req_byte_en[BE_W*win +: BE_W];
                    wd   = req_write_data[DW*win +: DW];
                    exp_ready[win] = 1'b1;
                    check("bank_addr", 64'(bank_addr[BAW*b +: BAW]), 64'(off));
                    check("bank_read_en", 64'(bank_read_en[b]), 64'(!req_we[win]));
                    check("bank_write_en", 64'(bank_write_en[b]), 64'(req_we[win]));
                    check("bank_byte_en", 64'(bank_byte_en[BE_W*b +: BE_W]),
                          req_we[win] ? 64'(be_i) : 64'(4'hF));
                    check("bank_write_data", 64'(bank_write_data[DW*b +: DW]), 64'(wd));
                    if (req_we[win]) begin
                        cur = ref_mem[b][off];
                        for (int k = 0; k < BE_W; k++)
                            if (be_i[k]) cur[8*k +: 8] = wd[8*k +: 8];
                        ref_mem[b][off] = cur;
                    end else begin
                        e.due  = cycle + 1;
                        e.data = ref_mem[b][off];
                        exp_q[win].push_back(e);
                    end
                    rr_m[b] = (win + 1) % N_REQ;
                end
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
        end
    end

    // Response monitor: pops an expectation whenever rsp_valid is seen.
    always @(negedge clock) begin : monitor
        exp_t e;
        for (int i = 0; i < N_REQ; i++) begin
            if (!reset) begin
                check("reset_rsp_valid", 64'(rsp_valid[i]), 64'(0));
                // Reads accepted just before reset are cancelled.
                while (exp_q[i].size() > 0 && exp_q[i][0].due <= cycle)
                    void'(exp_q[i].pop_front());
            end else if (rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid[i]), 64'(0));
                end else begin
                    e = exp_q[i].pop_front();
                    check("rsp_timing", 64'(cycle), 64'(e.due));
                    check("rsp_read_data", 64'(rsp_read_data[DW*i +: DW]), 64'(e.data));
                end
            end else begin
                check("rsp_data_zero", 64'(rsp_read_data[DW*i +: DW]), 64'(0));
                if (exp_q[i].size() > 0 && exp_q[i][0].due == cycle) begin
                    check("rsp_missing", 64'(rsp_valid[i]), 64'(1));
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic we, input int bank,
                           input int off, input logic [BE_W-1:0] be, input logic [DW-1:0] wd);
        req_valid[i]                   = v;
        req_we[i]                      = we;
        req_addr[A_W*i +: A_W]         = A_W'(bank * DEPTH + off);
        req_byte_en[BE_W*i +: BE_W]    = be;
        req_write_data[DW*i +: DW]     = wd;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 1'b0, 0, 0, '0, '0);
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic next_cycle();
        @(negedge clock);
        s_ready     = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_read_data;
        s_bank_re   = bank_read_en;
        s_bank_we   = bank_write_en;
        s_bank_be   = bank_byte_en;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] v;
        idle_all();
        for (int b = 0; b < N_BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                v = $urandom;
                sram[b][a]    = v;
                ref_mem[b][a] = v;
            end
        end
        sram[0][5]    = 32'hDEADBEEF;
        ref_mem[0][5] = 32'hDEADBEEF;
        repeat (3) next_cycle();
        reset = 1'b1;

        // Single read from requester 0.
        set_req(0, 1'b1, 1'b0, 0, 5, '0, '0);
        next_cycle();
        check("single_read_ready", 64'(s_ready), 64'(2'b01));
        check("single_read_strobe", 64'(s_bank_re), 64'(4'b0001));
        idle_all();
        next_cycle();
        check("single_read_rsp_valid", 64'(s_rsp_valid), 64'(2'b01));
        check("single_read_data", 64'(s_rsp_data[DW-1:0]), 64'(32'hDEADBEEF));

        // Parallel banks: read bank 1 and write bank 2 in one cycle.
        set_req(0, 1'b1, 1'b0, 1, 'h20, '0, '0);
        set_req(1, 1'b1, 1'b1, 2, 'h40, 4'b0011, 32'h12345678);
        next_cycle();
        check("parallel_ready", 64'(s_ready), 64'(2'b11));
        check("parallel_read_en", 64'(s_bank_re), 64'(4'b0010));
        check("parallel_write_en", 64'(s_bank_we), 64'(4'b0100));
        check("parallel_byte_en", 64'(s_bank_be[BE_W*2 +: BE_W]), 64'(4'b0011));
        set_req(0, 1'b1, 1'b0, 2, 'h40, '0, '0);  // read back the merged word
        set_req(1, 1'b0, 1'b0, 0, 0, '0, '0);
        next_cycle();
        idle_all();
        next_cycle();

        // Contention on bank 3 right after reset: grants alternate 0,1,0,1.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 3, 1, '0, '0);
        set_req(1, 1'b1, 1'b0, 3, 2, '0, '0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check("contention_grant", 64'(s_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
        end
        idle_all();
        next_cycle();

        // Back-to-back stream of reads by requester 1 across all of bank 0.
        for (int k = 0; k < DEPTH; k++) begin
            set_req(1, 1'b1, 1'b0, 0, k, '0, '0);
            next_cycle();
            check("stream_ready", 64'(s_ready), 64'(2'b10));
        end
        idle_all();
        next_cycle();

        // Reset right after an accepted read: no response, pointer back to 0.
        set_req(0, 1'b1, 1'b0, 0, 7, '0, '0);
        next_cycle();
        idle_all();
        reset = 1'b0;
        next_cycle();
        check("reset_cancels_rsp", 64'(s_rsp_valid), 64'(0));
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 0, 8, '0, '0);
        set_req(1, 1'b1, 1'b0, 0, 9, '0, '0);
        next_cycle();
        check("post_reset_grant", 64'(s_ready), 64'(2'b01));
        idle_all();

        // Idle: no strobes, pointers hold (bank 0 now favours requester 1).
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            check("idle_strobes", 64'({s_bank_re, s_bank_we}), 64'(0));
        end
        set_req(0, 1'b1, 1'b0, 0, 3, '0, '0);
        set_req(1, 1'b1, 1'b0, 0, 4, '0, '0);
        next_cycle();
        check("idle_rr_hold", 64'(s_ready), 64'(2'b10));
        idle_all();
        next_cycle();

        // Random traffic; a request is held until granted.
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) begin
                idle_all();
                reset = 1'b0;
                next_cycle();
                reset = 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || s_ready[i]) begin
                    if ($urandom_range(0, 9) < 7)
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, N_BANKS-1),
                                $urandom_range(0, 15), BE_W'($urandom), $urandom);
                    else
                        set_req(i, 1'b0, 1'b0, 0, 0, '0, '0);
                end
            end
            next_cycle();
        end

        idle_all();
        repeat (3) next_cycle();
        for (int i = 0; i < N_REQ; i++)
            check("rsp_queue_drained", 64'(exp_q[i].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
